// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer: a CPU write to DMA_REG_ADDR freezes the core and copies
// page $XX00-$XXFF into PPU OAM as 256 read/write pairs aimed at OAM_DATA_ADDR.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph2_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rnw,
    input  logic [7:0]  cpu_data_in,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rnw,
    output logic [7:0]  dma_data_out,
    output logic        dma_busy
);

    // Bus ownership: cpu_rdy=0 freezes the core for the whole halt/align/copy
    // window; dma_active=1 only in READ/WRITE cycles, when the upstream mux
    // must take dma_addr/dma_rnw/dma_data_out instead of the core's bus.
    // ARM covers the rest of the trigger cycle so HALT spans one full cycle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_HALT  = 3'd2,
        S_ALIGN = 3'd3,
        S_READ  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    state_t      state, state_next;
    logic        parity;
    logic        cycle_seen;
    logic [7:0]  page, page_next;
    logic [7:0]  idx, idx_next;
    logic        trigger;

    logic        cpu_rdy_next;
    logic        dma_active_next;
    logic [15:0] dma_addr_next;
    logic        dma_rnw_next;
    logic [7:0]  dma_data_next;
    logic        dma_busy_next;

    assign trigger = (state == S_IDLE) && ph2_falling && !cpu_rnw &&
                     (cpu_addr == DMA_REG_ADDR);

    // parity is the parity of the current CPU cycle; the first cycle after reset is even
    always_ff @(posedge clk) begin
        if (rst) begin
            parity     <= 1'b0;
            cycle_seen <= 1'b0;
        end else if (ph2_rising) begin
            if (cycle_seen) begin
                parity <= ~parity;
            end
            cycle_seen <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        page_next       = page;
        idx_next        = idx;
        cpu_rdy_next    = cpu_rdy;
        dma_active_next = dma_active;
        dma_addr_next   = dma_addr;
        dma_rnw_next    = dma_rnw;
        dma_data_next   = dma_data_out;
        dma_busy_next   = dma_busy;

        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    page_next     = cpu_data_in;
                    idx_next      = 8'h00;
                    dma_busy_next = 1'b1;
                    state_next    = S_ARM;
                end
            end
            S_ARM: begin
                if (ph2_rising) begin
                    state_next      = S_HALT;
                    cpu_rdy_next    = 1'b0;
                    dma_active_next = 1'b0;
                    dma_rnw_next    = 1'b1;
                end
            end
            S_HALT: begin
                // Old parity is that of the HALT cycle; odd here means the next one is a get cycle.
                if (ph2_rising) begin
                    if (parity) begin
                        state_next      = S_READ;
                        dma_active_next = 1'b1;
                        dma_rnw_next    = 1'b1;
                        dma_addr_next   = {page, idx};
                    end else begin
                        state_next = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (ph2_rising) begin
                    state_next      = S_READ;
                    dma_active_next = 1'b1;
                    dma_rnw_next    = 1'b1;
                    dma_addr_next   = {page, idx};
                end
            end
            S_READ: begin
                // Memory data is only valid on the strobe clk itself.
                if (ph2_falling) begin
                    dma_data_next = mem_data_in;
                end
                if (ph2_rising) begin
                    state_next      = S_WRITE;
                    dma_active_next = 1'b1;
                    dma_rnw_next    = 1'b0;
                    dma_addr_next   = OAM_DATA_ADDR;
                end
            end
            S_WRITE: begin
                if (ph2_rising) begin
                    if (idx == 8'hFF) begin
                        state_next      = S_IDLE;
                        idx_next        = 8'h00;
                        cpu_rdy_next    = 1'b1;
                        dma_active_next = 1'b0;
                        dma_rnw_next    = 1'b1;
                        dma_busy_next   = 1'b0;
                    end else begin
                        state_next      = S_READ;
                        idx_next        = idx + 8'd1;
                        dma_active_next = 1'b1;
                        dma_rnw_next    = 1'b1;
                        dma_addr_next   = {page, idx + 8'd1};
                    end
                end
            end
            default: begin
                state_next      = S_IDLE;
                cpu_rdy_next    = 1'b1;
                dma_active_next = 1'b0;
                dma_rnw_next    = 1'b1;
                dma_busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            page         <= 8'h00;
            idx          <= 8'h00;
            cpu_rdy      <= 1'b1;
            dma_active   <= 1'b0;
            dma_addr     <= 16'h0000;
            dma_rnw      <= 1'b1;
            dma_data_out <= 8'h00;
            dma_busy     <= 1'b0;
        end else begin
            state        <= state_next;
            page         <= page_next;
            idx          <= idx_next;
            cpu_rdy      <= cpu_rdy_next;
            dma_active   <= dma_active_next;
            dma_addr     <= dma_addr_next;
            dma_rnw      <= dma_rnw_next;
            dma_data_out <= dma_data_next;
            dma_busy     <= dma_busy_next;
        end
    end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sprite DMA sequencer for the NES CPU bus. It decodes a CPU write to $4014 and halts the CPU through `cpu_rdy`. It then becomes bus master and copies the 256-byte page `$XX00-$XXFF` from the memory manager into PPU OAM, using read/write pairs to $2004. It sits between the CPU core and the memory manager / PPU register bus. A bus mux upstream selects the DMA address and data whenever `dma_active` is high.

## Interface
Parameters:
- `DMA_REG_ADDR`, default 16'h4014: CPU address that triggers DMA.
- `OAM_DATA_ADDR`, default 16'h2004: target address for every write.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `ph2_rising`  in  1: one-clk strobe marking the start of a CPU cycle.
- `ph2_falling`  in  1: one-clk strobe marking mid-cycle; bus data is committed here.
- `cpu_addr`  in  16: CPU core address.
- `cpu_rnw`  in  1: CPU core read/not-write.
- `cpu_data_in`  in  8: CPU core write data.
- `mem_data_in`  in  8: read data returned by the memory manager (its `cpu_data_out`).
- `cpu_rdy`  out  1: high means the CPU may run; low freezes the core.
- `dma_active`  out  1: high while DMA owns the bus.
- `dma_addr`  out  16: DMA bus address.
- `dma_rnw`  out  1: DMA read/not-write.
- `dma_data_out`  out  8: DMA write data.
- `dma_busy`  out  1: high from the trigger until the transfer completes.

## Operation
- Reset values: `cpu_rdy`=1, `dma_active`=0, `dma_addr`=0, `dma_rnw`=1, `dma_data_out`=0, `dma_busy`=0. Reset also sets state=IDLE, `parity`=0, `idx`=0 and `page`=0.
- `parity` toggles on every `ph2_rising`. The first CPU cycle after reset has `parity`=0. Even cycles are "get" cycles and odd cycles are "put" cycles.
- Trigger: in IDLE, a clk where `ph2_falling` is high, `cpu_rnw`=0 and `cpu_addr`==`DMA_REG_ADDR`.
  - Latch `page`<=`cpu_data_in` and `idx`<=0.
  - Set `dma_busy`<=1 and enter state HALT.
- All state transitions below occur on `ph2_rising` only. The state register holds between strobes.
- HALT (1 CPU cycle): `cpu_rdy`=0, `dma_active`=0.
  - At the next `ph2_rising`, go to READ if the starting cycle is even; otherwise go to ALIGN.
- ALIGN (1 CPU cycle): `cpu_rdy`=0, `dma_active`=0. Next state is READ.
- READ (even cycle): `dma_active`=1, `dma_rnw`=1, `dma_addr`={`page`,`idx`}.
  - At `ph2_falling`, latch `dma_data_out`<=`mem_data_in`. This must be sampled on the same clk as the strobe, before the memory manager clears its output.
  - Next state is WRITE.
- WRITE (odd cycle): `dma_active`=1, `dma_rnw`=0, `dma_addr`=`OAM_DATA_ADDR`, `dma_data_out` held from READ.
  - At `ph2_rising`: if `idx`==8'hFF, go to IDLE; otherwise `idx`<=`idx`+1 (8-bit) and go to READ.
- IDLE: `cpu_rdy`=1, `dma_active`=0, `dma_rnw`=1, `dma_busy`=0. `dma_addr` holds its last value.
- `idx` wraps 8'hFF->8'h00 only at completion; the page number never increments.
- A write to `DMA_REG_ADDR` while not in IDLE is ignored. The CPU is frozen then, so only a bench can produce it.
- Page source is unrestricted ($00-$FF); PPU-register or unmapped pages are copied as-is.
- `rst` asserted mid-transfer: on the next clk, go to IDLE with all outputs at reset values and no further bus cycles. OAM contents already written are not rolled back.

## Timing
- Trigger write in CPU cycle W.
  - HALT occupies cycle W+1.
  - First READ occurs in W+2 if W+2 is even; otherwise ALIGN occupies W+2 and the first READ is in W+3.
- `cpu_rdy` falls at `ph2_rising` of W+1. It returns to 1 at the `ph2_rising` after the final WRITE cycle.
- CPU stall is 513 cycles (no ALIGN) or 514 cycles (with ALIGN).
- `dma_active` is high for exactly 512 CPU cycles.
- Outputs are registered and update on the clk carrying `ph2_rising` (state outputs) or `ph2_falling` (data latch).
- Read data latency: byte read in cycle N is written to `OAM_DATA_ADDR` in cycle N+1.

## Test plan
- Reset, then CPU writes 8'h02 to $4014 with W+2 even -> 256 pairs; reads $0200..$02FF, writes $2004 with matching bytes; `cpu_rdy` low for exactly 513 cycles.
- Same write with W+2 odd -> one ALIGN cycle with `dma_active`=0; `cpu_rdy` low for 514 cycles.
- RAM $0300+i preloaded with i XOR 8'hA5, trigger page 8'h03 -> 256 $2004 writes in order carrying 8'hA5, 8'hA4, ... 8'h5A; last write followed by IDLE and `dma_busy`=0.
- Force a second $4014 write (value 8'h07) during transfer of page 8'h02 -> ignored; all reads remain in page $02; total count still 256.
- Assert `rst` at idx=8'h40 during WRITE -> next clk `cpu_rdy`=1, `dma_active`=0, `dma_rnw`=1; no further $2004 writes; a new trigger afterwards runs a full 256-byte transfer.
- Write 8'h02 to $4015 and read $4014 -> no DMA; `cpu_rdy` stays 1.
